pulse_trigger_sequencer: RTL and testbench

Sequencer for the AOM pulse-generator datapath. It detects the TTL trigger on an ADC channel with hysteresis, applies a programmable start delay, and produces the waveform-RAM read address stream for a programmable pulse length. Between pulses it schedules the ADC-offset measurement windows and integrator hold. Its outputs drive the error/waveform RAM readout, the offset averager and the integrator gating.

---
 rtl/pulse_trigger_sequencer_if.sv | 29 ++
 rtl/pulse_trigger_sequencer.sv | 114 +++++++++++
 tb/tb_pulse_trigger_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_trigger_sequencer_if.sv
// pulse_trigger_sequencer_if: trigger sample, pulse configuration and sequencer outputs bundled as one port.
interface pulse_trigger_sequencer_if #(
  parameter int AW = 13,
  parameter int DW = 14
);
  logic signed [DW-1:0] trig_dat_i;
  logic cfg_arm_i;
  logic cfg_single_i;
  logic cfg_clr_i;
  logic [AW-1:0] cfg_len_i;
  logic [AW-1:0] cfg_delay_i;
  logic rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic busy_o;
  logic int_hold_o;
  logic off_win_o;
  logic off_done_o;
  logic done_o;
  logic ovr_o;
  logic [15:0] pulse_cnt_o;
  modport master (
    output trig_dat_i, cfg_arm_i, cfg_single_i, cfg_clr_i, cfg_len_i, cfg_delay_i,
    input rd_en_o, rd_addr_o, busy_o, int_hold_o, off_win_o, off_done_o, done_o, ovr_o, pulse_cnt_o
  );
  modport slave (
    input trig_dat_i, cfg_arm_i, cfg_single_i, cfg_clr_i, cfg_len_i, cfg_delay_i,
    output rd_en_o, rd_addr_o, busy_o, int_hold_o, off_win_o, off_done_o, done_o, ovr_o, pulse_cnt_o
  );
endinterface

// File: rtl/pulse_trigger_sequencer.sv
// pulse_trigger_sequencer: hysteretic ADC trigger, delayed waveform read stream, offset windows and integrator hold.
module pulse_trigger_sequencer #(
  parameter int AW = 13,
  parameter int DW = 14,
  parameter int signed THRESH = 750,
  parameter int signed HYST = 64,
  parameter int OFF_LEN = 64
) (
  input logic clk_i,
  input logic rst_i,
  pulse_trigger_sequencer_if.slave bus
);
  localparam int OW = $clog2(OFF_LEN);
  typedef enum logic [1:0] {IDLE, DELAY, PLAY, WAIT_LOW} state_t;
  state_t state_q, state_d;
  logic trig_q, trig_d, done_q, done_d, ovr_q, ovr_d, win_q, win_d, offd_q, offd_d;
  logic [AW-1:0] addr_q, addr_d, cnt_q, cnt_d, len_q, len_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [OW-1:0] ocnt_q, ocnt_d;
  logic signed [DW-1:0] samp;
  logic hi, lo, rise, fall, accept, set_done, set_ovr;
  always_comb begin
    samp = bus.trig_dat_i;
    hi = int'(samp) >= THRESH;
    lo = int'(samp) < THRESH - HYST;
    trig_d = hi ? 1'b1 : (lo ? 1'b0 : trig_q);
    rise = hi & ~trig_q;
    fall = lo & trig_q;
    accept = rise & bus.cfg_arm_i & ~(bus.cfg_single_i & done_q);
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    len_d = len_q;
    set_done = 1'b0;
    set_ovr = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        len_d = bus.cfg_len_i;
        cnt_d = bus.cfg_delay_i;
        addr_d = '0;
        // rejected or empty triggers park in WAIT_LOW so the same level cannot retrigger
        state_d = (!accept || bus.cfg_len_i == '0) ? WAIT_LOW :
                  (bus.cfg_delay_i == '0 ? PLAY : DELAY);
      end
      DELAY: begin
        if (fall) begin
          state_d = IDLE;
          set_ovr = 1'b1;
        end else if (cnt_q == AW'(1)) begin
          state_d = PLAY;
          addr_d = '0;
        end else cnt_d = cnt_q - AW'(1);
      end
      PLAY: begin
        // completion wins over a fall on the final address
        if (addr_q == len_q - AW'(1)) begin
          state_d = WAIT_LOW;
          set_done = 1'b1;
        end else if (fall) begin
          state_d = IDLE;
          set_ovr = 1'b1;
        end else addr_d = addr_q + AW'(1);
      end
      default: if (fall || !trig_q) state_d = IDLE;
    endcase
  end
  always_comb begin
    done_d = bus.cfg_clr_i ? 1'b0 : (done_q | set_done);
    ovr_d = bus.cfg_clr_i ? 1'b0 : (ovr_q | set_ovr);
    pcnt_d = (set_done && pcnt_q != '1) ? pcnt_q + 16'd1 : pcnt_q;
    win_d = (state_d == IDLE) & ~trig_d;
    // counter restarts whenever the window opens, so partial windows never complete
    ocnt_d = (win_d && win_q && ocnt_q != OW'(OFF_LEN - 1)) ? ocnt_q + OW'(1) : '0;
    offd_d = win_d & (ocnt_d == OW'(OFF_LEN - 1));
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      trig_q <= 1'b0;
      addr_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
      pcnt_q <= '0;
      win_q <= 1'b0;
      offd_q <= 1'b0;
      ocnt_q <= '0;
    end else begin
      state_q <= state_d;
      trig_q <= trig_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      done_q <= done_d;
      ovr_q <= ovr_d;
      pcnt_q <= pcnt_d;
      win_q <= win_d;
      offd_q <= offd_d;
      ocnt_q <= ocnt_d;
    end
  end
  assign bus.rd_en_o = state_q == PLAY;
  assign bus.rd_addr_o = addr_q;
  assign bus.busy_o = state_q != IDLE;
  assign bus.int_hold_o = (state_q == IDLE) || (state_q == WAIT_LOW);
  assign bus.off_win_o = win_q;
  assign bus.off_done_o = offd_q;
  assign bus.done_o = done_q;
  assign bus.ovr_o = ovr_q;
  assign bus.pulse_cnt_o = pcnt_q;
endmodule

// File: tb/tb_pulse_trigger_sequencer.sv
// tb_pulse_trigger_sequencer: scoreboard bench; an event-level model predicts reads, offset pulses and flags per cycle.
module tb_pulse_trigger_sequencer;
  localparam int AW = 13, DW = 14, MAXN = 512;
  typedef struct {int cyc; int val;} ev_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  pulse_trigger_sequencer_if #(.AW(AW), .DW(DW)) bus();
  pulse_trigger_sequencer dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  ev_t rq[$], oq[$];
  int samp[MAXN], len[MAXN], dly[MAXN];
  bit arm[MAXN], sng[MAXN], clr[MAXN], rise[MAXN], fall[MAXN], setd[MAXN], seto[MAXN];
  bit lvl[MAXN+1], idle[MAXN+1], hold[MAXN+1], win[MAXN+1];
  int vals[12] = '{0, 600, 685, 686, 700, 749, 750, 760, 1000, -1000, 8191, -8192};
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit running = 1'b0;
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask
  function automatic bit flag_at(int c, bit is_done);
    for (int k = c - 1; k >= 0; k--) begin
      if (clr[k]) return 1'b0;
      if (is_done ? setd[k] : seto[k]) return 1'b1;
    end
    return 1'b0;
  endfunction
  function automatic int cnt_at(int c);
    int s = 0;
    for (int k = 0; k < c; k++) s += int'(setd[k]);
    return s > 65535 ? 65535 : s;
  endfunction
  task automatic mark(int a, int b, bit active, int n);
    for (int c = a; c <= b && c <= n; c++) begin
      idle[c] = 1'b0;
      if (active) hold[c] = 1'b0;
    end
  endtask
  // Walks the stimulus trigger by trigger: level with hysteresis, then whole pulses as cycle ranges.
  task automatic model(int n);
    int t, w, c, start, last, ab, ende, run;
    bit hi, lo;
    lvl[0] = 1'b0;
    for (int k = 0; k < n; k++) begin
      hi = samp[k] >= 750;
      lo = samp[k] < 686;
      rise[k] = hi && !lvl[k];
      fall[k] = lo && lvl[k];
      lvl[k+1] = hi ? 1'b1 : (lo ? 1'b0 : lvl[k]);
      setd[k] = 1'b0;
      seto[k] = 1'b0;
    end
    for (int k = 0; k <= n; k++) begin
      idle[k] = 1'b1;
      hold[k] = 1'b1;
    end
    t = 0;
    while (t < n) begin
      if (!rise[t]) begin
        t++;
        continue;
      end
      w = t + 1;
      if (arm[t] && !(sng[t] && flag_at(t, 1'b1)) && len[t] > 0) begin
        start = t + 1 + dly[t];
        last = start + len[t] - 1;
        ab = -1;
        for (int f = t + 1; f < last && f < n; f++)
          if (fall[f]) begin
            ab = f;
            break;
          end
        ende = ab >= 0 ? ab : last;
        mark(t + 1, ende, 1'b1, n);
        for (int k = start; k <= ende && k < n; k++) rq.push_back('{k, k - start});
        if (ab >= 0) begin
          seto[ab] = 1'b1;
          t = ab + 1;
          continue;
        end
        if (last >= n) break;
        setd[last] = 1'b1;
        w = last + 1;
      end
      c = w;
      while (c < n && !(fall[c] || !lvl[c])) c++;
      mark(w, c, 1'b0, n);
      t = c + 1;
    end
    run = 0;
    for (int k = 0; k < n; k++) begin
      win[k] = k > 0 && idle[k] && !lvl[k];
      run = win[k] ? run + 1 : 0;
      if (win[k] && run % 64 == 0) oq.push_back('{k, 0});
    end
  endtask
  task automatic drive(int k);
    bus.trig_dat_i = samp[k][DW-1:0];
    bus.cfg_arm_i = arm[k];
    bus.cfg_single_i = sng[k];
    bus.cfg_clr_i = clr[k];
    bus.cfg_len_i = len[k][AW-1:0];
    bus.cfg_delay_i = dly[k][AW-1:0];
  endtask
  task automatic fill_default(int n);
    for (int k = 0; k < n; k++) begin
      samp[k] = 0;
      arm[k] = 1'b1;
      sng[k] = 1'b0;
      clr[k] = 1'b0;
      len[k] = 4;
      dly[k] = 0;
    end
  endtask
  task automatic seg(int a, int b, int v);
    for (int k = a; k <= b; k++) samp[k] = v;
  endtask
  task automatic fill_random(int n);
    int k = 0, sl, v;
    bit s = 1'($urandom % 2);
    while (k < n) begin
      sl = 1 + int'($urandom % 12);
      v = vals[$urandom % 12];
      for (int j = 0; j < sl && k < n; j++) begin
        samp[k] = v;
        arm[k] = ($urandom % 8) != 0;
        sng[k] = s;
        clr[k] = ($urandom % 30) == 0;
        len[k] = int'($urandom % 7);
        dly[k] = int'($urandom % 5);
        k++;
      end
    end
  endtask
  task automatic run_batch(int n);
    rq.delete();
    oq.delete();
    model(n);
    @(posedge clk);
    #1 rst = 1'b1;
    cyc = 0;
    drive(0);
    @(negedge clk);
    #1 rst = 1'b0;
    running = 1'b1;
    for (int k = 1; k < n; k++) begin
      @(posedge clk);
      #1 cyc = k;
      drive(k);
    end
    @(negedge clk);
    #1 running = 1'b0;
    chk("reads_left", rq.size(), 0);
    chk("offdone_left", oq.size(), 0);
  endtask
  always @(negedge clk) begin
    if (running && !rst) begin
      automatic int c = cyc;
      automatic ev_t e;
      chk("busy", int'(bus.busy_o), int'(!idle[c]));
      chk("int_hold", int'(bus.int_hold_o), int'(hold[c]));
      chk("off_win", int'(bus.off_win_o), int'(win[c]));
      chk("done", int'(bus.done_o), int'(flag_at(c, 1'b1)));
      chk("ovr", int'(bus.ovr_o), int'(flag_at(c, 1'b0)));
      chk("pulse_cnt", int'(bus.pulse_cnt_o), cnt_at(c));
      if (bus.rd_en_o) begin
        if (rq.size() == 0) chk("rd_unexpected", int'(bus.rd_addr_o), -1);
        else begin
          e = rq.pop_front();
          chk("rd_cycle", c, e.cyc);
          chk("rd_addr", int'(bus.rd_addr_o), e.val);
        end
      end
      if (bus.off_done_o) begin
        if (oq.size() == 0) chk("offdone_unexpected", c, -1);
        else begin
          e = oq.pop_front();
          chk("offdone_cycle", c, e.cyc);
        end
      end
    end
  end
  initial begin
    fill_default(1);
    len[0] = 100;
    drive(0);
    repeat (2) @(posedge clk);
    #1 chk("rst_int_hold", int'(bus.int_hold_o), 1);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_off_win", int'(bus.off_win_o), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.trig_dat_i = 14'sd1000;
    repeat (6) @(posedge clk);
    #1 chk("midplay_rd_en", int'(bus.rd_en_o), 1);
    chk("midplay_addr", int'(bus.rd_addr_o), 5);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("async_rst_rd_en", int'(bus.rd_en_o), 0);
    chk("async_rst_busy", int'(bus.busy_o), 0);
    chk("async_rst_cnt", int'(bus.pulse_cnt_o), 0);
    chk("async_rst_hold", int'(bus.int_hold_o), 1);
    chk("async_rst_addr", int'(bus.rd_addr_o), 0);
    fill_default(400);
    seg(100, 109, 1000);
    for (int k = 140; k < 195; k++) begin
      len[k] = 2;
      dly[k] = 3;
    end
    for (int k = 195; k < 400; k++) len[k] = 2;
    seg(150, 151, 1000);
    seg(170, 180, 1000);
    seg(200, 205, 760);
    seg(206, 210, 700);
    seg(211, 215, 760);
    seg(216, 220, 600);
    seg(221, 225, 760);
    run_batch(400);
    fill_default(200);
    for (int k = 0; k < 200; k++) sng[k] = 1'b1;
    seg(20, 24, 1000);
    seg(40, 44, 1000);
    seg(60, 64, 1000);
    clr[70] = 1'b1;
    seg(80, 84, 1000);
    seg(100, 104, 1000);
    run_batch(200);
    for (int b = 0; b < 12; b++) begin
      fill_random(300);
      run_batch(300);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
